// File: rtl/oct_ram_pkg.sv
// Shared definitions for the OCT dual-port RAM family: read modes, clear FSM
// states and configuration helpers.
package oct_ram_pkg;

   localparam int READ_FIRST  = 0;
   localparam int WRITE_FIRST = 1;
   localparam int NO_CHANGE   = 2;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } ram_state_e;

   function automatic int nb(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

   function automatic bit cfg_ok(input int data_width, input int byte_width,
                                 input int depth, input int addr_width);
      return (byte_width > 0) && (data_width % byte_width == 0) &&
             (depth > 0) && (depth <= (1 << addr_width));
   endfunction

endpackage

// File: rtl/tdp_ram_rdport.sv
// One read port of tdp_ram_bw: same-port read-during-write selection, optional
// second output stage and valid tracking.
module tdp_ram_rdport
   import oct_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BYTE_WIDTH = 8,
   parameter int READ_MODE  = 0,
   parameter int OUT_REG    = 0
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      accept,
   input  logic                                      in_range,
   input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0]     we,
   input  logic [DATA_WIDTH-1:0]                     din,
   input  logic [DATA_WIDTH-1:0]                     rd_word,
   output logic [DATA_WIDTH-1:0]                     dout,
   output logic                                      valid
);

   localparam int NB = nb(DATA_WIDTH, BYTE_WIDTH);

   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] dout1_d, dout1_q;
   logic                  valid1_d, valid1_q;

   always_comb begin
      merged = rd_word;
      for (int b = 0; b < NB; b++) begin
         if (we[b]) merged[b*BYTE_WIDTH +: BYTE_WIDTH] = din[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // rd_word is already zero for out-of-range addresses, so those reads stay valid.
   always_comb begin
      dout1_d  = dout1_q;
      valid1_d = 1'b0;
      if (accept) begin
         if (!((|we) && (READ_MODE == NO_CHANGE))) begin
            valid1_d = 1'b1;
            if ((|we) && (READ_MODE == WRITE_FIRST) && in_range) dout1_d = merged;
            else                                                  dout1_d = rd_word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout1_q  <= '0;
         valid1_q <= 1'b0;
      end else begin
         dout1_q  <= dout1_d;
         valid1_q <= valid1_d;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] dout2_q;
      logic                  valid2_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout2_q  <= '0;
            valid2_q <= 1'b0;
         end else begin
            dout2_q  <= dout1_q;
            valid2_q <= valid1_q;
         end
      end

      assign dout  = dout2_q;
      assign valid = valid2_q;
   end else begin : g_no_out_reg
      assign dout  = dout1_q;
      assign valid = valid1_q;
   end

endmodule

// File: rtl/tdp_ram_bw.sv
// True dual-port RAM with byte enables, A-priority collision merge, collision
// flag and a post-reset zero-fill sequencer.
module tdp_ram_bw
   import oct_ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 6,
   parameter int DATA_WIDTH     = 8,
   parameter int BYTE_WIDTH     = 8,
   parameter int DEPTH          = 34,
   parameter int READ_MODE      = 0,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   output logic                                  init_done,
   input  logic                                  ena,
   input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0] wea,
   input  logic [ADDR_WIDTH-1:0]                 addra,
   input  logic [DATA_WIDTH-1:0]                 dina,
   output logic [DATA_WIDTH-1:0]                 douta,
   output logic                                  valida,
   input  logic                                  enb,
   input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0] web,
   input  logic [ADDR_WIDTH-1:0]                 addrb,
   input  logic [DATA_WIDTH-1:0]                 dinb,
   output logic [DATA_WIDTH-1:0]                 doutb,
   output logic                                  validb,
   output logic                                  coll
);

   localparam int NB = nb(DATA_WIDTH, BYTE_WIDTH);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

   if (!cfg_ok(DATA_WIDTH, BYTE_WIDTH, DEPTH, ADDR_WIDTH)) begin : g_bad_cfg
      $error("tdp_ram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH and DEPTH <= 2**ADDR_WIDTH");
   end

`ifdef XILINX
   (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
`else
   logic [DATA_WIDTH-1:0] mem [DEPTH];
`endif

   ram_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  init_done_q, init_done_d;
   logic                  coll_q, coll_d;
   logic                  run, in_rng_a, in_rng_b;
   logic [NB-1:0]         we_a, we_b;
   logic [DATA_WIDTH-1:0] rd_a, rd_b;

   assign run      = (state_q == RUN);
   assign in_rng_a = ({1'b0, addra} < DEPTH_W);
   assign in_rng_b = ({1'b0, addrb} < DEPTH_W);
   assign we_a     = (run && ena && in_rng_a) ? wea : '0;
   assign we_b     = (run && enb && in_rng_b) ? web : '0;
   assign rd_a     = in_rng_a ? mem[addra] : '0;
   assign rd_b     = in_rng_b ? mem[addrb] : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == CLEAR) begin
         if ((CLEAR_ON_RESET == 0) || (ptr_q == LAST)) state_d = RUN;
         else                                          ptr_d   = ptr_q + 1'b1;
      end
      init_done_d = (state_d == RUN);
      coll_d      = run && ena && enb && in_rng_a && (addra == addrb) && ((|wea) || (|web));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         ptr_q       <= '0;
         init_done_q <= 1'b0;
         coll_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         init_done_q <= init_done_d;
         coll_q      <= coll_d;
      end
   end

   // Port B bytes are assigned first so port A's later assignment wins on overlap.
   always_ff @(posedge clk) begin
      if ((state_q == CLEAR) && (CLEAR_ON_RESET != 0)) begin
         mem[ptr_q] <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (we_b[b]) mem[addrb][b*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[b*BYTE_WIDTH +: BYTE_WIDTH];
         end
         for (int b = 0; b < NB; b++) begin
            if (we_a[b]) mem[addra][b*BYTE_WIDTH +: BYTE_WIDTH] <= dina[b*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   tdp_ram_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .READ_MODE  (READ_MODE),
      .OUT_REG    (OUT_REG)
   ) u_rdport_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept   (run && ena),
      .in_range (in_rng_a),
      .we       (wea),
      .din      (dina),
      .rd_word  (rd_a),
      .dout     (douta),
      .valid    (valida)
   );

   tdp_ram_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .READ_MODE  (READ_MODE),
      .OUT_REG    (OUT_REG)
   ) u_rdport_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept   (run && enb),
      .in_range (in_rng_b),
      .we       (web),
      .din      (dinb),
      .rd_word  (rd_b),
      .dout     (doutb),
      .valid    (validb)
   );

   assign init_done = init_done_q;
   assign coll      = coll_q;

endmodule

// File: tb/tb_tdp_ram_bw.sv
// Directed bench for tdp_ram_bw: five instances sharing one stimulus stream
// (read-first, write-first, no-change, output-registered, no-clear).
module tb_tdp_ram_bw;

   localparam int RF = 0;
   localparam int WF = 1;
   localparam int NC = 2;
   localparam int OR = 3;
   localparam int NZ = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        ena, enb;
   logic [1:0]  wea, web;
   logic [5:0]  addra, addrb;
   logic [15:0] dina, dinb;

   logic [15:0] douta_w [5];
   logic [15:0] doutb_w [5];
   logic        valida_w [5];
   logic        validb_w [5];
   logic        coll_w [5];
   logic        init_w [5];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 5; i++) begin : g_dut
      tdp_ram_bw #(
         .ADDR_WIDTH     (6),
         .DATA_WIDTH     (16),
         .BYTE_WIDTH     (8),
         .DEPTH          (34),
         .READ_MODE      ((i == 1) ? 1 : ((i == 2) ? 2 : 0)),
         .OUT_REG        ((i == 3) ? 1 : 0),
         .CLEAR_ON_RESET ((i == 4) ? 0 : 1)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .init_done (init_w[i]),
         .ena       (ena),
         .wea       (wea),
         .addra     (addra),
         .dina      (dina),
         .douta     (douta_w[i]),
         .valida    (valida_w[i]),
         .enb       (enb),
         .web       (web),
         .addrb     (addrb),
         .dinb      (dinb),
         .doutb     (doutb_w[i]),
         .validb    (validb_w[i]),
         .coll      (coll_w[i])
      );
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ena = 1'b0; enb = 1'b0; wea = 2'b00; web = 2'b00;
      addra = '0; addrb = '0; dina = '0; dinb = '0;
   endtask

   task automatic wr_a(input logic [5:0] a, input logic [15:0] d, input logic [1:0] we);
      ena = 1'b1; wea = we; addra = a; dina = d;
      step();
      ena = 1'b0; wea = 2'b00;
   endtask

   task automatic rd_a(input logic [5:0] a);
      ena = 1'b1; wea = 2'b00; addra = a;
      step();
      ena = 1'b0;
   endtask

   task automatic rd_b(input logic [5:0] a);
      enb = 1'b1; web = 2'b00; addrb = a;
      step();
      enb = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      int bad;
      idle();
      rst_n = 1'b0;
      #2;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if ({douta_w[i], doutb_w[i], valida_w[i], validb_w[i], coll_w[i], init_w[i]} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got %h expected 0", i,
                     {douta_w[i], doutb_w[i], valida_w[i], validb_w[i], coll_w[i], init_w[i]});
         end
      end
      repeat (2) step();
      ena = 1'b1; addra = 6'd33; enb = 1'b1; addrb = 6'd0;
      rst_n = 1'b1;
      step();
      cnt = 1;
      bad = (valida_w[RF] || validb_w[RF]) ? 1 : 0;
      n_tests++;
      if (init_w[NZ] !== 1'b1) begin
         n_fail++;
         $display("FAIL noclear_init_done: got %b expected 1", init_w[NZ]);
      end
      while (init_w[RF] !== 1'b1 && cnt < 100) begin
         step();
         cnt++;
         if (valida_w[RF] || validb_w[RF]) bad++;
      end
      idle();
      n_tests++;
      if (cnt != 34) begin
         n_fail++;
         $display("FAIL init_done_latency: got %0d cycles expected 34", cnt);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL valid_during_clear: got %0d valid cycles expected 0", bad);
      end
   endtask

   task automatic test_mid_clear_reset();
      int cnt;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      repeat (10) step();
      n_tests++;
      if (init_w[RF] !== 1'b0) begin
         n_fail++;
         $display("FAIL init_at_clear_cycle10: got %b expected 0", init_w[RF]);
      end
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      cnt = 0;
      while (init_w[RF] !== 1'b1 && cnt < 100) begin
         step();
         cnt++;
      end
      n_tests++;
      if (cnt != 34) begin
         n_fail++;
         $display("FAIL refill_latency: got %0d cycles expected 34", cnt);
      end
   endtask

   task automatic test_clear_read();
      ena = 1'b1; addra = 6'd33; wea = 2'b00;
      enb = 1'b1; addrb = 6'd0;  web = 2'b00;
      step();
      idle();
      n_tests++;
      if (douta_w[RF] !== 16'h0000 || valida_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_read_a33: got %h/%b expected 0000/1", douta_w[RF], valida_w[RF]);
      end
      n_tests++;
      if (doutb_w[RF] !== 16'h0000 || validb_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_read_b0: got %h/%b expected 0000/1", doutb_w[RF], validb_w[RF]);
      end
   endtask

   task automatic test_partial_and_disable();
      wr_a(6'd5, 16'h1234, 2'b11);
      wr_a(6'd5, 16'hAB00, 2'b01);
      rd_a(6'd5);
      n_tests++;
      if (douta_w[RF] !== 16'h1200 || valida_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_write: got %h/%b expected 1200/1", douta_w[RF], valida_w[RF]);
      end
      ena = 1'b0; wea = 2'b11; addra = 6'd5; dina = 16'hFFFF;
      step();
      n_tests++;
      if (douta_w[RF] !== 16'h1200 || valida_w[RF] !== 1'b0) begin
         n_fail++;
         $display("FAIL disabled_hold: got %h/%b expected 1200/0", douta_w[RF], valida_w[RF]);
      end
      idle();
      rd_b(6'd5);
      n_tests++;
      if (doutb_w[RF] !== 16'h1200) begin
         n_fail++;
         $display("FAIL disabled_no_write: got %h expected 1200", doutb_w[RF]);
      end
   endtask

   task automatic test_write_collision();
      ena = 1'b1; wea = 2'b11; addra = 6'd5; dina = 16'hAAAA;
      enb = 1'b1; web = 2'b11; addrb = 6'd5; dinb = 16'hBBBB;
      step();
      idle();
      n_tests++;
      if (coll_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL ww_coll_pulse: got %b expected 1", coll_w[RF]);
      end
      n_tests++;
      if (douta_w[RF] !== 16'h1200) begin
         n_fail++;
         $display("FAIL ww_read_first_old: got %h expected 1200", douta_w[RF]);
      end
      step();
      n_tests++;
      if (coll_w[RF] !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_one_cycle: got %b expected 0", coll_w[RF]);
      end
      rd_a(6'd5);
      n_tests++;
      if (douta_w[RF] !== 16'hAAAA) begin
         n_fail++;
         $display("FAIL ww_a_priority: got %h expected AAAA", douta_w[RF]);
      end
      wr_a(6'd5, 16'h1234, 2'b11);
      ena = 1'b1; wea = 2'b10; addra = 6'd5; dina = 16'hAAAA;
      enb = 1'b1; web = 2'b01; addrb = 6'd5; dinb = 16'hBBBB;
      step();
      idle();
      n_tests++;
      if (coll_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL split_coll_pulse: got %b expected 1", coll_w[RF]);
      end
      rd_a(6'd5);
      n_tests++;
      if (douta_w[RF] !== 16'hAABB) begin
         n_fail++;
         $display("FAIL split_byte_merge: got %h expected AABB", douta_w[RF]);
      end
   endtask

   task automatic test_read_modes();
      wr_a(6'd7, 16'h1111, 2'b11);
      rd_a(6'd5);
      ena = 1'b1; wea = 2'b11; addra = 6'd7; dina = 16'h2222;
      enb = 1'b1; web = 2'b00; addrb = 6'd7;
      step();
      idle();
      n_tests++;
      if (douta_w[RF] !== 16'h1111 || valida_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL read_first: got %h/%b expected 1111/1", douta_w[RF], valida_w[RF]);
      end
      n_tests++;
      if (douta_w[WF] !== 16'h2222 || valida_w[WF] !== 1'b1) begin
         n_fail++;
         $display("FAIL write_first: got %h/%b expected 2222/1", douta_w[WF], valida_w[WF]);
      end
      n_tests++;
      if (douta_w[NC] !== 16'hAABB || valida_w[NC] !== 1'b0) begin
         n_fail++;
         $display("FAIL no_change: got %h/%b expected AABB/0", douta_w[NC], valida_w[NC]);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (doutb_w[i] !== 16'h1111 || validb_w[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL cross_read_old dut%0d: got %h/%b expected 1111/1", i, doutb_w[i], validb_w[i]);
         end
      end
      n_tests++;
      if (coll_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL rw_coll_pulse: got %b expected 1", coll_w[RF]);
      end
      rd_b(6'd7);
      n_tests++;
      if (doutb_w[RF] !== 16'h2222) begin
         n_fail++;
         $display("FAIL write_visible: got %h expected 2222", doutb_w[RF]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [4];
      vals[0] = 16'h0A01; vals[1] = 16'h0B02; vals[2] = 16'h0C03; vals[3] = 16'h0D04;
      for (int i = 0; i < 4; i++) wr_a(6'(i), vals[i], 2'b11);
      repeat (2) step();
      for (int e = 1; e <= 6; e++) begin
         if (e <= 4) begin
            ena = 1'b1; wea = 2'b00; addra = 6'(e - 1);
         end else begin
            ena = 1'b0;
         end
         step();
         n_tests++;
         if (valida_w[OR] !== ((e >= 2) && (e <= 5))) begin
            n_fail++;
            $display("FAIL oreg_valid edge%0d: got %b expected %b", e, valida_w[OR], ((e >= 2) && (e <= 5)));
         end
         if (e >= 2 && e <= 5) begin
            n_tests++;
            if (douta_w[OR] !== vals[e-2]) begin
               n_fail++;
               $display("FAIL oreg_data edge%0d: got %h expected %h", e, douta_w[OR], vals[e-2]);
            end
         end
         if (e <= 4) begin
            n_tests++;
            if (douta_w[RF] !== vals[e-1] || valida_w[RF] !== 1'b1) begin
               n_fail++;
               $display("FAIL lat1_data edge%0d: got %h/%b expected %h/1", e, douta_w[RF], valida_w[RF], vals[e-1]);
            end
         end
      end
      idle();
   endtask

   task automatic test_out_of_range();
      wr_a(6'd40, 16'h5A5A, 2'b11);
      rd_a(6'd7);
      rd_a(6'd40);
      n_tests++;
      if (douta_w[RF] !== 16'h0000 || valida_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL oor_read: got %h/%b expected 0000/1", douta_w[RF], valida_w[RF]);
      end
      rd_a(6'd8);
      n_tests++;
      if (douta_w[RF] !== 16'h0000) begin
         n_fail++;
         $display("FAIL oor_no_alias8: got %h expected 0000", douta_w[RF]);
      end
      rd_b(6'd6);
      n_tests++;
      if (doutb_w[RF] !== 16'h0000) begin
         n_fail++;
         $display("FAIL oor_no_alias6: got %h expected 0000", doutb_w[RF]);
      end
      ena = 1'b1; wea = 2'b11; addra = 6'd40; dina = 16'h1357;
      enb = 1'b1; web = 2'b11; addrb = 6'd40; dinb = 16'h2468;
      step();
      idle();
      n_tests++;
      if (coll_w[RF] !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_no_coll: got %b expected 0", coll_w[RF]);
      end
      n_tests++;
      if (doutb_w[RF] !== 16'h0000 || validb_w[RF] !== 1'b1) begin
         n_fail++;
         $display("FAIL oor_read_b: got %h/%b expected 0000/1", doutb_w[RF], validb_w[RF]);
      end
   endtask

   initial begin
      idle();
      #2;
      test_reset();
      test_mid_clear_reset();
      test_clear_read();
      test_partial_and_disable();
      test_write_collision();
      test_read_modes();
      test_back_to_back();
      test_out_of_range();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tdp_ram_bw.md
# tdp_ram_bw

Parametrised true dual-port RAM with per-byte write enables, per-port enables and a selectable same-port read mode. It adds an optional output register stage with read-valid tracking, deterministic cross-port collision resolution with a collision flag, and a post-reset clear sequencer. It is the shared buffer primitive for the MAC datapath (weight, activation and gradient staging) and replaces the plain two-port array in new OCT blocks.

## Interface
Parameters:
- ADDR_WIDTH, 6, address width in bits; 2**ADDR_WIDTH ≥ DEPTH.
- DATA_WIDTH, 8, word width; must be an integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, write-enable granularity; NB = DATA_WIDTH/BYTE_WIDTH.
- DEPTH, 34, number of words.
- READ_MODE, 0, same-port read-during-write behaviour: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- OUT_REG, 0, 1 adds a second output register stage.
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- init_done  out  1  high once the array is usable.
- ena / enb  in  1  port access enable.
- wea / web  in  NB  per-byte write enable, qualified by ena/enb.
- addra / addrb  in  ADDR_WIDTH  word address.
- dina / dinb  in  DATA_WIDTH  write data.
- douta / doutb  out  DATA_WIDTH  read data.
- valida / validb  out  1  douta/doutb carries data of an accepted read.
- coll  out  1  one-cycle pulse on a same-address cross-port conflict.

## Operation
- Async reset: douta, doutb, valida, validb, coll, init_done = 0. The clear pointer goes to 0. Array contents are not reset.
- FSM states CLEAR and RUN:
  - CLEAR_ON_RESET=1: after reset, enter CLEAR and write 0 to address ptr, ptr+1 each cycle. After writing DEPTH-1, enter RUN. Port inputs are ignored in CLEAR and valida/validb stay 0.
  - CLEAR_ON_RESET=0: enter RUN directly; contents are X in simulation.
  - Reset asserted mid-CLEAR restarts the fill from address 0.
- Accesses are accepted only in RUN. Each enabled port performs a read every cycle; it also writes the bytes whose enable is 1.
- Same-port read mode, applied when ena=1 with any wea bit set:
  - READ_FIRST: dout returns the old word.
  - WRITE_FIRST: dout returns the merged new word.
  - NO_CHANGE: dout holds and valid is 0.
- Port disabled: no write, dout holds its value, valid = 0.
- Address ≥ DEPTH: the write is dropped; the read returns 0 with valid = 1.
- Cross-port, same in-range address, both enabled:
  - Write-write: for each byte, port A wins where both enables are set. Bytes enabled by only one port take that port's data.
  - Read vs write: the reading port always sees the old word, regardless of READ_MODE.
  - coll pulses when at least one port writes.
- Partial writes leave the unenabled bytes unchanged.

## Timing
- Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from the enabled edge to dout/valid.
- With OUT_REG=1, the second stage always advances; valid is pipelined alongside the data.
- A write is visible to either port's read issued on the following edge.
- coll registers one cycle after the conflicting access.
- init_done rises the cycle after the last clear write: DEPTH cycles after reset release, or 1 cycle when CLEAR_ON_RESET=0.
- Throughput is one access per port per cycle, with no back-pressure.

## Structure
- Package oct_ram_pkg:
  - READ_FIRST, WRITE_FIRST and NO_CHANGE constants.
  - FSM state typedef (CLEAR, RUN).
  - Function nb(DATA_WIDTH, BYTE_WIDTH).
  - Elaboration checks: DATA_WIDTH % BYTE_WIDTH == 0 and DEPTH ≤ 2**ADDR_WIDTH.
- Top level holds the array, byte-merge write logic with A-priority, the clear FSM and the collision detector.
- Sub-module tdp_ram_rdport, instantiated twice, handles read-mode selection, the optional output stage and valid generation.
- Keep the array in a single always block per port for block-RAM inference; the Xilinx ram_style attribute stays under the Xilinx define.

## Test plan
Bench parameters: DATA_WIDTH=16, BYTE_WIDTH=8, DEPTH=34.
- Release reset, CLEAR_ON_RESET=1 -> init_done rises exactly 34 cycles later; a read of address 33 returns 0x0000 with valida=1. Reset asserted at clear cycle 10 -> a fresh 34-cycle fill follows.
- addra=5 with word 0x1234: wea=2'b01, dina=0xAB00 -> a readback of address 5 returns 0x1200. A port disabled during an access -> its dout holds and valid = 0.
- Same-cycle write to address 5: wea=2'b11 with dina=0xAAAA, web=2'b11 with dinb=0xBBBB -> the word reads 0xAAAA and coll pulses. With wea=2'b10 and web=2'b01 -> the word reads 0xAABB and coll pulses.
- Address 7 holding 0x1111; port A writes 0x2222 to it:
  - READ_MODE=0 -> douta=0x1111.
  - READ_MODE=1 -> douta=0x2222.
  - READ_MODE=2 -> douta holds its prior value and valida=0.
  - Port B reading address 7 in the same cycle gets 0x1111 in all modes.
- OUT_REG=1, back-to-back reads of addresses 0..3 -> data appears 2 cycles later, one word per cycle, with valid continuously high.
- Write to address 40 (≥ DEPTH) -> no array change; the read returns 0x0000 with valid=1.
